mem_bist: RTL and testbench
===========================

MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter ERR_W, default 16, error-counter width.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle run request.
REQ-007 SHALL have port mode  in  1  0 = March C-, 1 = address-as-data.
REQ-008 SHALL have port mem_req  out  1  transaction request.
REQ-009 SHALL have port mem_we  out  1  1 = write, 0 = read.
REQ-010 SHALL have port mem_addr  out  ADDR_W  word address.
REQ-011 SHALL have port mem_wdata  out  DATA_W  write data.
REQ-012 SHALL have port mem_ack  in  1  transaction complete.
REQ-013 SHALL have port mem_rdata  in  DATA_W  read data, valid on the ack cycle.
REQ-014 SHALL have outputs busy (1), done (1), pass (1), err_count (ERR_W), fail_addr (ADDR_W) and fail_data (DATA_W).

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, NEXT, DONE.
REQ-016 IDLE/DONE + start SHALL latch mode, clear err_count/fail_*, clear done, go to ISSUE next cycle.
REQ-017 start during ISSUE/WAIT/NEXT SHALL be ignored.
REQ-018 ISSUE SHALL assert mem_req with stable mem_we/addr/wdata, then go to WAIT.
REQ-019 mem_req, mem_we, mem_addr and mem_wdata SHALL hold until the cycle mem_ack=1; mem_ack while idle SHALL be ignored.
REQ-020 On the ack cycle mem_req SHALL fall on the next edge (state NEXT, one idle cycle), so each transaction takes at least 3 cycles.
REQ-021 March C- elements SHALL be, with 0=all-zeros, 1=all-ones, addresses 0..2^ADDR_W-1: M0 up w0; M1 up r0,w1; M2 down r1,w0; M3 up r0.
REQ-022 Within a multi-op element, all ops SHALL complete at one address before the address steps.
REQ-023 Address-as-data SHALL run A0 up write addr zero-extended/truncated to DATA_W, then A1 up read-compare the same value.
REQ-024 Each read SHALL compare mem_rdata to expected on the ack cycle; a mismatch SHALL increment err_count, saturating at all-ones.
REQ-025 The first mismatch of a run SHALL capture fail_addr=mem_addr and fail_data=mem_rdata; later mismatches SHALL not overwrite them.
REQ-026 After the last op of the last element the FSM SHALL enter DONE: done=1 and busy=0 until the next accepted start.
REQ-027 pass SHALL equal done AND (err_count==0).
REQ-028 busy SHALL be 1 in ISSUE, WAIT and NEXT.
REQ-029 Address counters SHALL wrap without overflow glitch at element boundaries (up ends at max, down ends at 0).

Reset
REQ-030 rst SHALL asynchronously force IDLE and zero every output (mem_req, mem_we, addr, wdata, busy, done, pass, err_count, fail_*).
REQ-031 Reset mid-transaction SHALL drop mem_req immediately; a pending mem_ack after reset SHALL be ignored.

Structure
REQ-032 The FSM state enum and the mode encoding SHALL live in the shared defines.svh package, using Bit_t for 1-bit signals.
REQ-033 One sub-module, mem_bist_seq (element/op/address sequencer producing we, addr, expected data and last flag), SHALL be used; compare, error logging and handshake SHALL stay in mem_bist.

Verification (bench: ADDR_W=4, DATA_W=8, behavioural memory with ack latency 1 and 3)
REQ-034 Good memory, mode=0 -> 96 transactions, done=1, pass=1, err_count=0, at both ack latencies.
REQ-035 Bit 3 stuck-at-0 at addr 5, mode=0 -> err_count=1, fail_addr=5, fail_data=8'hF7, pass=0.
REQ-036 Address bit 3 aliased (8..15 map to 0..7), mode=1 -> err_count=8, fail_addr=0, fail_data=8'h08.
REQ-037 rst pulse at the 40th transaction -> mem_req, busy and done go to 0 asynchronously; a new start then gives pass=1.
REQ-038 start pulsed while busy -> ignored, run completes with unchanged transaction count of 96.
REQ-039 ERR_W=4, rdata stuck at 8'hA5, mode=0 -> 48 read mismatches, err_count saturates at 15, fail_addr=0, fail_data=8'hA5.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared types for the memory BIST
package mem_bist_pkg;

  typedef logic Bit_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_e;

  typedef enum logic {MODE_MARCH = 1'b0, MODE_ADDR = 1'b1} mode_e;

  typedef enum logic [2:0] {EL_M0, EL_M1, EL_M2, EL_M3, EL_A0, EL_A1} elem_e;

  function automatic elem_e next_elem(elem_e e);
    case (e)
      EL_M0:   next_elem = EL_M1;
      EL_M1:   next_elem = EL_M2;
      EL_M2:   next_elem = EL_M3;
      EL_A0:   next_elem = EL_A1;
      default: next_elem = e;
    endcase
  endfunction

endpackage

// File: rtl/mem_bist_if.sv
// rtl/mem_bist_if.sv - request/ack memory port driven by the BIST
interface mem_bist_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_bist_seq.sv
// rtl/mem_bist_seq.sv - element/op/address walker for March C- and address-as-data
module mem_bist_seq
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  Bit_t              clk,
  input  Bit_t              rst,
  input  Bit_t              init,
  input  Bit_t              step,
  input  Bit_t              mode,
  output Bit_t              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output Bit_t              last
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  elem_e             elem_q, elem_d;
  Bit_t              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  Bit_t  down, last_op, addr_end, final_elem;
  elem_e elem_nx;

  always_comb begin
    down       = (elem_q == EL_M2);
    last_op    = !((elem_q == EL_M1) || (elem_q == EL_M2)) || op_q;
    addr_end   = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    final_elem = (elem_q == EL_M3) || (elem_q == EL_A1);
    last       = last_op && addr_end && final_elem;
    elem_nx    = next_elem(elem_q);

    we   = 1'b0;
    data = '0;
    case (elem_q)
      EL_M0: we = 1'b1;
      EL_M1: begin we = op_q; data = op_q ? '1 : '0; end
      EL_M2: begin we = op_q; data = op_q ? '0 : '1; end
      EL_A0: begin we = 1'b1; data = DATA_W'(addr_q); end
      EL_A1: data = DATA_W'(addr_q);
      default: ;
    endcase
  end

  always_comb begin
    elem_d = elem_q;
    op_d   = op_q;
    addr_d = addr_q;
    if (init) begin
      elem_d = (mode_e'(mode) == MODE_ADDR) ? EL_A0 : EL_M0;
      op_d   = 1'b0;
      addr_d = '0;
    end else if (step) begin
      if (!last_op) begin
        op_d = 1'b1;
      end else begin
        op_d = 1'b0;
        if (!addr_end) begin
          addr_d = down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end else begin
          // Element boundary: reload the start address for the new direction.
          elem_d = elem_nx;
          addr_d = (elem_nx == EL_M2) ? ADDR_MAX : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_q <= EL_M0;
      op_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      elem_q <= elem_d;
      op_q   <= op_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/mem_bist.sv
// rtl/mem_bist.sv - memory BIST: handshake FSM, read compare and error logging
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16
) (
  input  Bit_t              clk,
  input  Bit_t              rst,
  input  Bit_t              start,
  input  Bit_t              mode,
  mem_bist_if.master        mem,
  output Bit_t              busy,
  output Bit_t              done,
  output Bit_t              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  state_e            state_q, state_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  Bit_t              seq_init, seq_step, seq_we, seq_last, clr, mismatch, req;
  logic [ADDR_W-1:0] seq_addr;
  logic [DATA_W-1:0] seq_data;

  mem_bist_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_seq (
    .clk  (clk),
    .rst  (rst),
    .init (seq_init),
    .step (seq_step),
    .mode (mode),
    .we   (seq_we),
    .addr (seq_addr),
    .data (seq_data),
    .last (seq_last)
  );

  always_comb begin
    state_d  = state_q;
    seq_init = 1'b0;
    seq_step = 1'b0;
    clr      = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d  = ISSUE;
        seq_init = 1'b1;
        clr      = 1'b1;
      end
      ISSUE: state_d = WAIT;
      WAIT:  if (mem.mem_ack) state_d = NEXT;
      NEXT: begin
        if (seq_last) begin
          state_d = DONE;
        end else begin
          seq_step = 1'b1;
          state_d  = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only a read acked in WAIT is compared; stray acks elsewhere fall through.
  assign mismatch = (state_q == WAIT) && mem.mem_ack && !seq_we && (mem.mem_rdata != seq_data);

  always_comb begin
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (clr) begin
      err_d       = '0;
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if (mismatch) begin
      if (err_q == '0) begin
        fail_addr_d = seq_addr;
        fail_data_d = mem.mem_rdata;
      end
      if (err_q != '1) err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign req           = (state_q == ISSUE) || (state_q == WAIT);
  assign mem.mem_req   = req;
  assign mem.mem_we    = req && seq_we;
  assign mem.mem_addr  = req ? seq_addr : '0;
  assign mem.mem_wdata = (req && seq_we) ? seq_data : '0;

  assign busy      = req || (state_q == NEXT);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb/tb_mem_bist.sv - directed self-checking bench for mem_bist with a faultable memory
module tb_mem_bist;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          busy, done, pass;
  logic [EW-1:0] err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_bist #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .mem       (mif),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  always #5 clk = ~clk;

  // fault: 0 none, 1 bit3 stuck-at-0 at addr 5, 2 address bit 3 aliased, 3 rdata stuck at A5
  logic [7:0] mem_arr [16];
  int         lat = 1;
  int         fault = 0;
  int         lat_cnt = 0;
  logic       ack = 1'b0;
  logic       ack_force = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [3:0] idx;
  logic [7:0] wd;
  int         txn = 0;
  int         rd_txn = 0;
  logic       cnt_clr = 1'b0;
  int         checks = 0;
  int         errors = 0;

  assign mif.mem_ack   = ack | ack_force;
  assign mif.mem_rdata = rdata;

  always_comb begin
    idx = (fault == 2) ? {1'b0, mif.mem_addr[2:0]} : mif.mem_addr;
    wd  = (fault == 1 && mif.mem_addr == 4'd5) ? (mif.mem_wdata & 8'hF7) : mif.mem_wdata;
  end

  always @(posedge clk) begin
    if (ack) begin
      ack     <= 1'b0;
      lat_cnt <= 0;
    end else if (mif.mem_req) begin
      if (lat_cnt + 1 >= lat) begin
        ack     <= 1'b1;
        lat_cnt <= 0;
        if (mif.mem_we) mem_arr[idx] <= wd;
        else            rdata <= (fault == 3) ? 8'hA5 : mem_arr[idx];
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (cnt_clr) begin
      txn    <= 0;
      rd_txn <= 0;
    end else if (mif.mem_req && mif.mem_ack) begin
      txn <= txn + 1;
      if (!mif.mem_we) rd_txn <= rd_txn + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    mode    = m;
    start   = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic wait_done(input bit spam);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      start = spam && busy && (i % 7 == 3);
      if (spam && busy && i == 20) mode = ~mode;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_reached", ok, 1);
  endtask

  initial begin
    bit ok;

    #1 rst = 1'b1;
    #1;
    chk("rst_req",   mif.mem_req, 0);
    chk("rst_we",    mif.mem_we, 0);
    chk("rst_addr",  mif.mem_addr, 0);
    chk("rst_wdata", mif.mem_wdata, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_pass",  pass, 0);
    chk("rst_err",   err_count, 0);
    chk("rst_faddr", fail_addr, 0);
    chk("rst_fdata", fail_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // good memory, March C-, ack latency 1
    lat = 1; fault = 0;
    pulse_start(1'b0);
    chk("a_busy_issue", busy, 1);
    chk("a_req_issue",  mif.mem_req, 1);
    chk("a_first_we",   mif.mem_we, 1);
    chk("a_first_addr", mif.mem_addr, 0);
    wait_done(1'b0);
    chk("a_txn",   txn, 96);
    chk("a_reads", rd_txn, 48);
    chk("a_pass",  pass, 1);
    chk("a_err",   err_count, 0);
    chk("a_busy",  busy, 0);
    chk("a_req",   mif.mem_req, 0);

    // stray ack while done is ignored
    @(negedge clk); ack_force = 1'b1;
    @(negedge clk); ack_force = 1'b0;
    @(negedge clk);
    chk("idle_ack_done", done, 1);
    chk("idle_ack_req",  mif.mem_req, 0);
    chk("idle_ack_err",  err_count, 0);

    // good memory, ack latency 3; start from DONE clears done
    lat = 3;
    pulse_start(1'b0);
    chk("b_done_clr", done, 0);
    chk("b_busy",     busy, 1);
    wait_done(1'b0);
    chk("b_txn",  txn, 96);
    chk("b_pass", pass, 1);
    chk("b_err",  err_count, 0);

    // bit 3 stuck-at-0 at address 5
    lat = 1; fault = 1;
    pulse_start(1'b0);
    wait_done(1'b0);
    chk("c_err",   err_count, 1);
    chk("c_faddr", fail_addr, 5);
    chk("c_fdata", fail_data, 8'hF7);
    chk("c_pass",  pass, 0);
    chk("c_done",  done, 1);

    // address bit 3 aliased, address-as-data
    fault = 2;
    pulse_start(1'b1);
    wait_done(1'b0);
    chk("d_txn",   txn, 32);
    chk("d_err",   err_count, 8);
    chk("d_faddr", fail_addr, 0);
    chk("d_fdata", fail_data, 8'h08);
    chk("d_pass",  pass, 0);

    // read data stuck at A5: 48 mismatches saturate a 4-bit counter
    fault = 3;
    pulse_start(1'b0);
    wait_done(1'b0);
    chk("e_txn",   txn, 96);
    chk("e_reads", rd_txn, 48);
    chk("e_err",   err_count, 4'hF);
    chk("e_faddr", fail_addr, 0);
    chk("e_fdata", fail_data, 8'hA5);
    chk("e_pass",  pass, 0);

    // reset during the 40th transaction
    pulse_start(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (txn >= 39 && mif.mem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("f_reach40", ok, 1);
    chk("f_err_pre", err_count != 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("f_req",   mif.mem_req, 0);
    chk("f_busy",  busy, 0);
    chk("f_done",  done, 0);
    chk("f_err",   err_count, 0);
    chk("f_faddr", fail_addr, 0);
    chk("f_fdata", fail_data, 0);
    chk("f_addr",  mif.mem_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fault = 0;
    repeat (3) @(negedge clk);
    chk("f_idle_busy", busy, 0);
    pulse_start(1'b0);
    wait_done(1'b0);
    chk("f_txn",  txn, 96);
    chk("f_pass", pass, 1);

    // start and mode toggled while busy must not disturb the run
    pulse_start(1'b0);
    wait_done(1'b1);
    chk("g_txn",  txn, 96);
    chk("g_pass", pass, 1);
    chk("g_err",  err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
